// File: rtl/mem_pkg.sv
// Shared types for the data-memory sequencer.
// Access sizes, FSM states and store masks.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    ISSUE,
    WAIT,
    RESP,
    ERR
  } dmc_state_t;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

endpackage

// File: rtl/load_extend.sv
// Load lane shift, size select, sign/zero extend.
// Ports: word/off/size/sgn in, res out (combinational).
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  mem_size_t   size,
  input  logic        sgn,
  output logic [31:0] res
);

  logic [31:0] sh;

  assign sh = word >> {off, 3'b000};

  always_comb begin
    res = sh;
    unique case (size)
      MEM_BYTE: res = {{24{sgn & sh[7]}}, sh[7:0]};
      MEM_HALF: res = {{16{sgn & sh[15]}}, sh[15:0]};
      default:  res = sh;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Execute-stage to block-RAM data memory sequencer.
// Ports: req/ctrl/addr/wdata in; stall/done/rdata/err out; mem_* BRAM side.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        MemRead,
  input  logic [3:0]  MemWrite,
  input  logic [1:0]  MemReadSize,
  input  logic        MemReadSigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  dmc_state_t  state, nxt;
  logic [31:0] addr_q, wdata_q, ext;
  logic [3:0]  mask_q;
  mem_size_t   size_q;
  logic        sgn_q, err_q;
  logic [1:0]  cnt;

  logic ld, st, half, word, badmask, illegal, accept;

  assign ld = MemRead;
  assign st = |MemWrite;

  assign half = (MemReadSize == 2'd1) | (MemWrite == MASK_H);
  assign word = (MemReadSize == 2'd2) | (MemWrite == MASK_W);

  assign badmask = st & ~((MemWrite == MASK_B) |
                          (MemWrite == MASK_H) |
                          (MemWrite == MASK_W));

  assign illegal = (ld & st) |
                   (MemReadSize == 2'd3) |
                   (half & addr[0]) |
                   (word & (|addr[1:0])) |
                   badmask;

  // Reset must force stall low even with a request pending.
  assign accept = ~rst & (state == IDLE) &
                  req_valid & (ld | st);

  assign err = err_q;

  load_extend u_ext (
    .word (mem_rdata),
    .off  (addr_q[1:0]),
    .size (size_q),
    .sgn  (sgn_q),
    .res  (ext)
  );

  always_comb begin
    nxt       = state;
    stall     = 1'b0;
    done      = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 4'b0000;
    mem_addr  = addr_q[31:2];
    mem_wdata = '0;
    unique case (state)
      IDLE: begin
        mem_addr = '0;
        if (accept) begin
          stall = 1'b1;
          if (illegal)  nxt = ERR;
          else if (st)  nxt = WRITE;
          else          nxt = ISSUE;
        end
      end
      WRITE: begin
        mem_en = 1'b1;
        mem_we = mask_q << addr_q[1:0];
        unique case (mask_q)
          MASK_B:  mem_wdata = {4{wdata_q[7:0]}};
          MASK_H:  mem_wdata = {2{wdata_q[15:0]}};
          default: mem_wdata = wdata_q;
        endcase
        done = 1'b1;
        nxt  = IDLE;
      end
      ISSUE: begin
        mem_en = 1'b1;
        stall  = 1'b1;
        nxt    = WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (cnt == 2'd0) nxt = RESP;
      end
      RESP: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      ERR: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      size_q  <= MEM_BYTE;
      sgn_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt     <= '0;
      rdata   <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        mask_q  <= MemWrite;
        size_q  <= mem_size_t'(MemReadSize);
        sgn_q   <= MemReadSigned;
        err_q   <= illegal;
      end else if (done) begin
        err_q <= 1'b0;
      end
      if (state == ISSUE)
        cnt <= CNT_INIT;
      else if (state == WAIT && cnt != 2'd0)
        cnt <= cnt - 2'd1;
      // Last WAIT cycle: memory word is valid now.
      if (state == WAIT && cnt == 2'd0)
        rdata <= ext;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Testbench for data_mem_ctrl at RD_LAT 1 and 3.
// Random and directed ops vs. a behavioural memory model.
module tb_data_mem_ctrl;

  localparam int LAT [2] = '{1, 3};

  logic        clk = 1'b0;
  logic        rst;
  logic        rv [2];
  logic        MemRead;
  logic [3:0]  MemWrite;
  logic [1:0]  MemReadSize;
  logic        MemReadSigned;
  logic [31:0] addr, wdata;

  logic        stall_o [2];
  logic        done_o  [2];
  logic        err_o   [2];
  logic        en_o    [2];
  logic [3:0]  we_o    [2];
  logic [29:0] ma_o    [2];
  logic [31:0] wd_o    [2];
  logic [31:0] rd_o    [2];
  logic [31:0] rdm     [2];

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  logic [31:0] pipe    [2][4];
  logic        mem_init = 1'b0;
  logic [31:0] exp_rd  [2];

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.RD_LAT(1)) u_l1 (
    .clk(clk), .rst(rst), .req_valid(rv[0]),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .MemReadSize(MemReadSize), .MemReadSigned(MemReadSigned),
    .addr(addr), .wdata(wdata),
    .stall(stall_o[0]), .done(done_o[0]), .rdata(rd_o[0]),
    .err(err_o[0]), .mem_en(en_o[0]), .mem_we(we_o[0]),
    .mem_addr(ma_o[0]), .mem_wdata(wd_o[0]), .mem_rdata(rdm[0])
  );

  data_mem_ctrl #(.RD_LAT(3)) u_l3 (
    .clk(clk), .rst(rst), .req_valid(rv[1]),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .MemReadSize(MemReadSize), .MemReadSigned(MemReadSigned),
    .addr(addr), .wdata(wdata),
    .stall(stall_o[1]), .done(done_o[1]), .rdata(rd_o[1]),
    .err(err_o[1]), .mem_en(en_o[1]), .mem_we(we_o[1]),
    .mem_addr(ma_o[1]), .mem_wdata(wd_o[1]), .mem_rdata(rdm[1])
  );

  // BRAM model: byte-lane writes, read data after LAT cycles,
  // random junk on the read bus in all other cycles.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= $urandom;
      mem_init <= 1'b1;
    end
    for (int k = 0; k < 2; k++) begin
      if (en_o[k] && we_o[k] != 4'b0)
        for (int b = 0; b < 4; b++)
          if (we_o[k][b])
            mem[ma_o[k][7:0]][8*b +: 8] <= wd_o[k][8*b +: 8];
      for (int i = 3; i > 0; i--) pipe[k][i] <= pipe[k][i-1];
      pipe[k][0] <= (en_o[k] && we_o[k] == 4'b0) ?
                    mem[ma_o[k][7:0]] : $urandom;
    end
  end

  assign rdm[0] = pipe[0][0];
  assign rdm[1] = pipe[1][2];

  task automatic do_op(input int k, input logic ld,
                       input logic [3:0] mask,
                       input logic [1:0] size, input logic sgn,
                       input logic [31:0] a, input logic [31:0] wd,
                       input string nm);
    logic st, hf, wo, ill, wr;
    logic [3:0]  ewe;
    logic [31:0] ewd, v;
    int d, w;
    st = (mask != 4'b0);
    hf = (size == 2'd1) || (mask == 4'b0011);
    wo = (size == 2'd2) || (mask == 4'b1111);
    ill = (ld && st) || (size == 2'd3) || (hf && a[0]) ||
          (wo && a[1:0] != 2'b0) ||
          (st && !(mask inside {4'h1, 4'h3, 4'hF}));
    wr = st && !ill;
    d = (ill || !ld) ? 1 : 2 + LAT[k];
    ewe = mask << a[1:0];
    w = (mask == 4'h1) ? 1 : (mask == 4'h3) ? 2 : 4;
    ewd = 32'h0;
    for (int b = 0; b < 4; b++) ewd[8*b +: 8] = wd[8*(b % w) +: 8];
    if (ld && !ill) begin
      v = ref_mem[a[9:2]] >> (8 * a[1:0]);
      if (size == 2'd0) begin
        v = v & 32'hFF;
        if (sgn && v[7]) v = v | 32'hFFFFFF00;
      end else if (size == 2'd1) begin
        v = v & 32'hFFFF;
        if (sgn && v[15]) v = v | 32'hFFFF0000;
      end
      exp_rd[k] = v;
    end
    if (wr)
      for (int b = 0; b < 4; b++)
        if (ewe[b]) ref_mem[a[9:2]][8*b +: 8] = ewd[8*b +: 8];

    @(posedge clk); #1;
    MemRead = ld; MemWrite = mask; MemReadSize = size;
    MemReadSigned = sgn; addr = a; wdata = wd; rv[k] = 1'b1;
    for (int c = 0; c <= d; c++) begin
      @(negedge clk);
      ncmp++;
      if (stall_o[k] !== (c < d)) begin
        nerr++;
        $display("FAIL %s stall c%0d: got %b want %b",
                 nm, c, stall_o[k], (c < d));
      end
      ncmp++;
      if (done_o[k] !== (c == d)) begin
        nerr++;
        $display("FAIL %s done c%0d: got %b want %b",
                 nm, c, done_o[k], (c == d));
      end
      ncmp++;
      if (en_o[k] !== (c == 1 && !ill)) begin
        nerr++;
        $display("FAIL %s mem_en c%0d: got %b want %b",
                 nm, c, en_o[k], (c == 1 && !ill));
      end
      ncmp++;
      if (we_o[k] !== ((c == 1 && wr) ? ewe : 4'b0)) begin
        nerr++;
        $display("FAIL %s mem_we c%0d: got %b want %b", nm, c,
                 we_o[k], ((c == 1 && wr) ? ewe : 4'b0));
      end
      ncmp++;
      if (ma_o[k] !== ((c == 0) ? 30'h0 : a[31:2])) begin
        nerr++;
        $display("FAIL %s mem_addr c%0d: got %h want %h", nm, c,
                 ma_o[k], ((c == 0) ? 30'h0 : a[31:2]));
      end
      if (c == 1 && wr) begin
        ncmp++;
        if (wd_o[k] !== ewd) begin
          nerr++;
          $display("FAIL %s mem_wdata: got %h want %h",
                   nm, wd_o[k], ewd);
        end
      end
      if (c == d) begin
        ncmp++;
        if (err_o[k] !== ill) begin
          nerr++;
          $display("FAIL %s err: got %b want %b", nm, err_o[k], ill);
        end
        ncmp++;
        if (rd_o[k] !== exp_rd[k]) begin
          nerr++;
          $display("FAIL %s rdata: got %h want %h",
                   nm, rd_o[k], exp_rd[k]);
        end
      end
    end
    @(posedge clk); #1;
    rv[k] = 1'b0; MemRead = 1'b0; MemWrite = 4'b0;
    @(negedge clk);
    ncmp++;
    if (stall_o[k] !== 1'b0 || done_o[k] !== 1'b0) begin
      nerr++;
      $display("FAIL %s after-done: got stall %b done %b want 0 0",
               nm, stall_o[k], done_o[k]);
    end
  endtask

  task automatic check_zero(input int k, input string nm);
    ncmp++;
    if ({stall_o[k], done_o[k], err_o[k], en_o[k]} !== 4'b0 ||
        we_o[k] !== 4'b0 || ma_o[k] !== 30'h0 ||
        wd_o[k] !== 32'h0 || rd_o[k] !== 32'h0) begin
      nerr++;
      $display("FAIL %s outputs: got s%b d%b e%b en%b we%h ma%h wd%h rd%h want all 0",
               nm, stall_o[k], done_o[k], err_o[k], en_o[k],
               we_o[k], ma_o[k], wd_o[k], rd_o[k]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero(0, "reset_l1");
    check_zero(1, "reset_l3");
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    exp_rd[0] = 32'h0;
    exp_rd[1] = 32'h0;
    rst = 1'b0;
  endtask

  task automatic test_store();
    do_op(0, 1'b0, 4'h1, 2'd0, 1'b0, 32'h103, 32'hAABBCCDD, "sb");
    do_op(0, 1'b0, 4'h3, 2'd0, 1'b0, 32'h2A, 32'h11223344, "sh");
    do_op(0, 1'b0, 4'hF, 2'd0, 1'b0, 32'h100, 32'h12F45678, "sw");
    do_op(1, 1'b0, 4'hF, 2'd0, 1'b0, 32'h200, 32'hCAFEF00D, "sw3");
  endtask

  task automatic test_load();
    do_op(0, 1'b1, 4'h0, 2'd0, 1'b1, 32'h102, 32'h0, "lb");
    ncmp++;
    if (rd_o[0] !== 32'hFFFFFFF4) begin
      nerr++;
      $display("FAIL lb_const: got %h want FFFFFFF4", rd_o[0]);
    end
    do_op(0, 1'b1, 4'h0, 2'd0, 1'b0, 32'h102, 32'h0, "lbu");
    ncmp++;
    if (rd_o[0] !== 32'h000000F4) begin
      nerr++;
      $display("FAIL lbu_const: got %h want 000000F4", rd_o[0]);
    end
    do_op(1, 1'b1, 4'h0, 2'd2, 1'b0, 32'h200, 32'h0, "lw3");
    ncmp++;
    if (rd_o[1] !== 32'hCAFEF00D) begin
      nerr++;
      $display("FAIL lw3_const: got %h want CAFEF00D", rd_o[1]);
    end
    do_op(1, 1'b1, 4'h0, 2'd1, 1'b1, 32'h102, 32'h0, "lh3");
  endtask

  task automatic test_errors();
    do_op(0, 1'b1, 4'h0, 2'd1, 1'b1, 32'h101, 32'h0, "lh_mis");
    do_op(0, 1'b0, 4'hF, 2'd0, 1'b0, 32'h102, 32'h5, "sw_mis");
    do_op(1, 1'b1, 4'hF, 2'd2, 1'b0, 32'h100, 32'h5, "rd_wr");
    do_op(1, 1'b1, 4'h0, 2'd3, 1'b0, 32'h100, 32'h0, "size3");
    do_op(0, 1'b0, 4'h6, 2'd0, 1'b0, 32'h100, 32'h7, "badmask");
  endtask

  task automatic test_inactive();
    @(posedge clk); #1;
    rv[0] = 1'b1; MemRead = 1'b0; MemWrite = 4'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      ncmp++;
      if (stall_o[0] !== 1'b0 || done_o[0] !== 1'b0) begin
        nerr++;
        $display("FAIL inactive c%0d: got stall %b done %b want 0 0",
                 c, stall_o[0], done_o[0]);
      end
    end
    rv[0] = 1'b0;
  endtask

  task automatic test_reset_midflight();
    @(posedge clk); #1;
    MemRead = 1'b1; MemWrite = 4'b0; MemReadSize = 2'd2;
    MemReadSigned = 1'b0; addr = 32'h200; rv[1] = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero(1, "rst_wait");
    check_zero(0, "rst_other");
    rv[1] = 1'b0; MemRead = 1'b0;
    exp_rd[0] = 32'h0;
    exp_rd[1] = 32'h0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      ncmp++;
      if (done_o[1] !== 1'b0 || rd_o[1] !== 32'h0) begin
        nerr++;
        $display("FAIL rst_late c%0d: got done %b rdata %h want 0 0",
                 c, done_o[1], rd_o[1]);
      end
    end
    do_op(1, 1'b1, 4'h0, 2'd2, 1'b0, 32'h200, 32'h0, "lw_after");
  endtask

  task automatic test_random();
    int k, kind;
    logic ld, sg;
    logic [3:0] m;
    logic [1:0] sz;
    logic [31:0] a;
    logic [3:0] legal_m [3];
    legal_m[0] = 4'h1; legal_m[1] = 4'h3; legal_m[2] = 4'hF;
    for (int n = 0; n < 80; n++) begin
      k = int'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 3));
      a = $urandom;
      sg = 1'($urandom);
      ld = 1'b0; m = 4'h0; sz = 2'd0;
      if (kind < 2) begin
        ld = 1'b1;
        sz = 2'($urandom_range(0, 2));
        if ($urandom_range(0, 1) == 0) a[1:0] = 2'b0;
      end else if (kind == 2) begin
        m = legal_m[$urandom_range(0, 2)];
        if ($urandom_range(0, 1) == 0) a[1:0] = 2'b0;
      end else begin
        ld = 1'($urandom);
        m = 4'($urandom);
        sz = 2'($urandom);
        if (!ld && m == 4'h0) m = 4'h5;
      end
      do_op(k, ld, m, sz, sg, a, $urandom, "rand");
    end
  endtask

  initial begin
    rv[0] = 1'b0; rv[1] = 1'b0;
    MemRead = 1'b0; MemWrite = 4'b0; MemReadSize = 2'd0;
    MemReadSigned = 1'b0; addr = 32'h0; wdata = 32'h0;
    test_reset();
    test_store();
    test_load();
    test_errors();
    test_inactive();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Multi-cycle sequencer between the execute stage and the FPGA block-RAM data memory. It takes the memory control signals produced by `main_control_unit` (MemRead, MemWrite, MemReadSize, MemReadSigned), the ALU address and the store data. It issues one aligned word access with byte-lane enables, stalls the pipeline through the memory read latency, and returns a size- and sign-extended load result. Misaligned or illegal requests are rejected without touching memory.

## Interface
Parameters:
- RD_LAT, 1: memory read latency in cycles from `mem_en` to valid `mem_rdata`; legal range 1..4.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  execute stage presents a memory op; held stable until `done`
- MemRead  in  1  load request
- MemWrite  in  4  store byte mask, lane-0 aligned: 0001 SB, 0011 SH, 1111 SW
- MemReadSize  in  2  0 byte, 1 half, 2 word; 3 illegal
- MemReadSigned  in  1  sign-extend load when 1
- addr  in  32  byte address from ALU
- wdata  in  32  store data (rs2)
- stall  out  1  freeze PC and pipeline registers
- done  out  1  one-cycle pulse at completion
- rdata  out  32  registered extended load result
- err  out  1  registered; valid in the `done` cycle; misaligned or illegal request
- mem_en  out  1  memory access strobe
- mem_we  out  4  byte write enables, lane-shifted
- mem_addr  out  30  word address, addr[31:2]
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  raw memory word

## Operation
- FSM states: IDLE, WRITE, ISSUE, WAIT, RESP, ERR.
- Acceptance happens only in IDLE, when `req_valid` is high and the request is active (MemRead=1 or MemWrite≠0).
  - On acceptance, addr, wdata, mask, size and signed are latched.
  - `req_valid` with an inactive request is ignored: no stall and no `done`.
  - `req_valid` outside IDLE is ignored.
- Illegal request → ERR. Illegal means any of:
  - MemRead=1 together with MemWrite≠0;
  - MemReadSize=3;
  - half access (size 1 or mask 0011) with addr[0]=1;
  - word access (size 2 or mask 1111) with addr[1:0]≠0;
  - a store mask other than 0001, 0011 or 1111.
- Legal store → WRITE:
  - `mem_en`=1.
  - `mem_we` = mask << addr[1:0].
  - `mem_wdata`: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
  - `done`=1, then return to IDLE.
- Legal load:
  - ISSUE: `mem_en`=1, `mem_we`=0; latency counter loaded with RD_LAT−1.
  - WAIT: holds while the counter is nonzero, decrementing each cycle.
  - The ISSUE/WAIT path runs for exactly RD_LAT cycles after ISSUE. At the end of cycle ISSUE+RD_LAT, `mem_rdata` is extended and registered into `rdata`.
  - Extension: shift right by 8·addr[1:0], select byte/half/word, then sign- or zero-extend.
  - Next state is RESP: `done`=1, err=0, then IDLE.
- ERR: no memory access; `done`=1, err=1, `rdata` unchanged, then IDLE.
- `mem_addr` is driven from the latched address in all non-IDLE states and is 0 in IDLE.
- `mem_en` and `mem_we` are 0 outside WRITE and ISSUE.

## Timing
- Cycle 0 is the acceptance cycle.
- `stall` is combinational:
  - high in cycle 0, and in every non-IDLE state except the `done` cycle;
  - low in the `done` cycle, so the pipeline advances at the end of that cycle.
- Store and error: `done` in cycle 1; `stall` high for 1 cycle.
- Load: ISSUE in cycle 1; `rdata` captured at the end of cycle 1+RD_LAT; `done` in cycle 2+RD_LAT; `stall` high for RD_LAT+2 cycles.
- No back-to-back acceptance in the `done` cycle. The next request is accepted at the earliest in the cycle after `done`.
- Reset, asserted at any time, acts immediately and asynchronously:
  - state → IDLE;
  - stall, done, err, mem_en → 0; mem_we, mem_addr, mem_wdata, rdata → 0.
  - An in-flight read is abandoned, and its late `mem_rdata` is ignored.

## Structure
- Shared package `mem_pkg` holds:
  - `mem_size_t` enum {MEM_BYTE=0, MEM_HALF=1, MEM_WORD=2};
  - the FSM state typedef `dmc_state_t`;
  - store mask constants MASK_B/MASK_H/MASK_W.
- One combinational sub-module, `load_extend`: lane shift plus size select plus sign/zero extension (inputs: raw word, addr[1:0], size, signed). It is reusable by the testbench as a reference model.

## Test plan
- SB, addr 0x00000103, wdata 0xAABBCCDD → cycle 1: mem_en=1, mem_we=1000, mem_wdata=0xDDDDDDDD, mem_addr=0x40, done=1, err=0.
- LB, addr 0x102, memory word 0x12F45678, RD_LAT=1 → rdata 0xFFFFFFF4 with done in cycle 3. The same access as LBU → 0x000000F4.
- LW, addr 0x200, RD_LAT=3, word 0xCAFEF00D → stall high in cycles 0–4, done in cycle 5, rdata 0xCAFEF00D, mem_en high in cycle 1 only.
- LH at addr 0x101, and SW at addr 0x102 → mem_en never asserted, done=1 and err=1 in cycle 1.
- MemRead=1 with MemWrite=1111 → err=1 in cycle 1. req_valid with MemRead=0 and MemWrite=0 → stall stays 0 and no done.
- rst pulsed during WAIT of an LW → all outputs 0 immediately, no done, and a later mem_rdata has no effect. The next LW completes normally with the correct rdata.
